// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The HALT state is only reachable when built with FETCH_ALIGN_CHECK_EN.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST        = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/inst_fetch_hold.sv
// inst_hold_reg: the IF/ID output slot (instruction, pc, valid).
// Loads as a whole when load=1; an async clear empties it to the NOP word.
module inst_hold_reg
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        load,
  input  logic [31:0] inst_d,
  input  logic [31:0] pc_d,
  input  logic        valid_d,
  output logic [31:0] inst_q,
  output logic [31:0] pc_q,
  output logic        valid_q
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      inst_q  <= NOP_INST;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC -> memory req/ack -> IF/ID slot, with stall/flush.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned PCs into the HALT state.
//
// state | meaning
// IDLE  | one cycle after reset, no request
// FETCH | issue requests whenever the output slot is free
// DROP  | a flushed request is still outstanding; wait for its ack, discard data
// HALT  | misaligned PC trapped (alignment check only); leave on flush
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] pc_in,
  output logic        pc_we,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        inst_exc
);

  fetch_state_e state, state_nxt;
  logic [31:0]  fetch_addr;
  logic [31:0]  drop_addr;
  logic         slot_free;
  logic         misaligned;
  logic         load;
  logic [31:0]  ld_inst;
  logic [31:0]  ld_pc;
  logic         ld_valid;

  assign fetch_addr = pc_in & WORD_ALIGN_MASK;
  assign slot_free  = !inst_valid || !stall;
  // The PC register moves at the flush edge, so DROP must replay the latched address.
  assign mem_addr   = (state == ST_DROP) ? drop_addr : fetch_addr;

`ifdef FETCH_ALIGN_CHECK_EN
  logic ld_exc;
  logic exc_q;

  assign misaligned = (pc_in[1:0] != 2'b00);
  assign inst_exc   = exc_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)     exc_q <= 1'b0;
    else if (load) exc_q <= ld_exc;
  end
`else
  assign misaligned = 1'b0;
  assign inst_exc   = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= ST_IDLE;
      drop_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && flush) drop_addr <= fetch_addr;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    pc_we     = 1'b0;
    load      = 1'b0;
    ld_inst   = NOP_INST;
    ld_pc     = inst_pc;
    ld_valid  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    ld_exc    = 1'b0;
`endif
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        mem_req = slot_free && !misaligned;
        if (flush) begin
          load = 1'b1;
          if (mem_req && !mem_ack) state_nxt = ST_DROP;
        end else if (mem_req && mem_ack) begin
          load     = 1'b1;
          ld_inst  = mem_rdata;
          ld_pc    = fetch_addr;
          ld_valid = 1'b1;
          pc_we    = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        end else if (slot_free && misaligned) begin
          load      = 1'b1;
          ld_pc     = pc_in;
          ld_valid  = 1'b1;
          ld_exc    = 1'b1;
          state_nxt = ST_HALT;
`endif
        end else if (inst_valid && !stall) begin
          load = 1'b1;
        end
      end
      ST_DROP: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = ST_FETCH;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      ST_HALT: begin
        if (flush) begin
          load      = 1'b1;
          state_nxt = ST_FETCH;
        end else if (inst_valid && !stall) begin
          load = 1'b1;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  inst_hold_reg u_hold (
    .clk     (clk),
    .clrn    (clrn),
    .load    (load),
    .inst_d  (ld_inst),
    .pc_d    (ld_pc),
    .valid_d (ld_valid),
    .inst_q  (inst_out),
    .pc_q    (inst_pc),
    .valid_q (inst_valid)
  );

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage between the 32-bit PC register and the IF/ID boundary. Reads the current PC, runs a req/ack handshake with instruction memory, and holds the fetched word with its PC until decode takes it. Drives the PC register's write enable, so the PC advances exactly once per accepted instruction. Handles decode stalls and pipeline flushes, including a flush that arrives while a memory access is outstanding.

## Interface
- NOP_INST, 32'h0000_0000, value driven on inst_out whenever inst_valid=0
- clk  input  1  clock, posedge
- clrn  input  1  reset, asynchronous, active-low
- pc_in  input  32  current PC from the PC register output
- pc_we  output  1  write enable to the PC register; combinational
- mem_req  output  1  instruction memory request
- mem_addr  output  32  word address, {pc_in[31:2],2'b00}
- mem_ack  input  1  memory response valid; may be asserted in the same cycle as mem_req
- mem_rdata  input  32  instruction word, valid when mem_ack=1
- stall  input  1  decode cannot accept this cycle
- flush  input  1  discard held and in-flight instructions; the PC register is redirected externally at the same edge
- inst_out  output  32  instruction to decode
- inst_pc  output  32  PC of inst_out
- inst_valid  output  1  output slot holds a live instruction
- inst_exc  output  1  misaligned-fetch marker (see Configuration)

## Operation
- States:
  - IDLE: entered on reset; lasts one cycle, then FETCH.
  - FETCH: issues requests.
  - DROP: a flushed request is still outstanding.
  - HALT: only with the alignment check enabled.
- Slot free condition: inst_valid=0, or the slot is consumed at this edge (inst_valid=1 and stall=0).
- Starting a request: in FETCH, mem_req is raised only when the slot is free.
- Holding a request: once mem_req=1 without mem_ack, mem_req stays high and mem_addr stays stable until the ack cycle. pc_in is not written while a request is outstanding.
- Capture on ack (FETCH, mem_ack=1, flush=0):
  - at the edge: inst_out<=mem_rdata, inst_pc<=mem_addr, inst_valid<=1.
  - pc_we=1 in that cycle.
- Consume without ack: slot consumed and no ack this cycle → inst_valid<=0.
- Ack never meets a full, stalled slot. A request starts only when the slot is free. If the request outlives its first cycle, the slot is empty from then on.
- Flush:
  - inst_valid<=0 at the edge; pc_we=0.
  - A same-cycle mem_ack is discarded.
  - If mem_req=1 and mem_ack=0 in the flush cycle, the next state is DROP.
- DROP: keep mem_req high on the old address until mem_ack; discard the data; pc_we=0; then return to FETCH. Further flushes while in DROP have no extra effect.
- stall has no effect on an empty slot.

## Timing
- Reset values:
  - state=IDLE, inst_valid=0, inst_out=NOP_INST, inst_pc=0, inst_exc=0.
  - mem_req=0, pc_we=0.
- Latency: PC sampled at the request cycle. With a zero-wait (same-cycle) ack, inst_valid is high in the next cycle.
- Throughput: one instruction per cycle with zero-wait memory and no stall.
- N wait cycles: mem_req is high for N+1 cycles; the instruction is valid at cycle N+2.
- pc_we is a single-cycle pulse, asserted only in an ack cycle with flush=0 (in FETCH).
- Reset mid-access: the state is dropped immediately; memory must tolerate an abandoned request.

## Configuration
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - In FETCH with the slot free and pc_in[1:0]!=0: no mem_req, pc_we=0.
  - Slot is loaded with inst_out=NOP_INST, inst_pc=pc_in, inst_valid=1, inst_exc=1.
  - Next state is HALT, which issues no requests and exits only on flush (to FETCH).
  - inst_exc clears when the slot is consumed or flushed.
- Undefined: pc_in[1:0] ignored, inst_exc tied 0, no HALT state.

## Structure
- Shared package holds:
  - the state enum encoding (IDLE, FETCH, DROP, HALT)
  - the default NOP word
  - the word-address alignment mask constant
- One sub-module: inst_hold_reg, a 65-bit slot register (inst, pc, valid) with load enable and async active-low clear. The FSM and handshake logic stay in inst_fetch.

## Test plan
- Reset release, zero-wait memory returning 32'h2408_0001 for pc 0x0 → mem_req at cycle 2; inst_valid with inst_out=32'h2408_0001, inst_pc=0 at cycle 3; one pc_we pulse.
- Stall for 3 cycles with the slot full → no mem_req, pc_we=0, and inst_out/inst_pc stable for 3 cycles; fetching resumes when stall drops.
- mem_ack delayed 4 cycles at pc 0x10 → mem_req high for 5 cycles with mem_addr=0x10 throughout, then a single pc_we pulse.
- Flush while a request is outstanding, then ack 2 cycles later with 32'hDEAD_BEEF → DROP state, data never appears on inst_out, pc_we stays 0, and the next fetch uses the redirected pc_in.
- Flush coincident with mem_ack → inst_valid=0 the next cycle, pc_we=0.
- With FETCH_ALIGN_CHECK_EN, pc_in=0x0000_0102 → no mem_req; inst_exc=1 with inst_pc=0x102; stays in HALT until flush.
